// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared MIPS control encodings: states, opcodes, ALU/PC selects.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : main_control_fsm_if
// Purpose  : Opcode/handshake inputs and datapath controls of the main FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface main_control_fsm_if;
    logic [5:0] Opcode;
    logic       Mem_ready;
    logic       PC_write;
    logic       PC_write_cond;
    logic       IorD;
    logic       Mem_read;
    logic       Mem_write;
    logic       IR_write;
    logic       Mem_to_reg;
    logic       Reg_dst;
    logic       Reg_write;
    logic       Alu_src_a;
    logic [1:0] Alu_src_b;
    logic [1:0] Alu_op;
    logic [1:0] PC_source;
    logic       Illegal_op;
    logic [3:0] State;

    modport master (
        input  Opcode, Mem_ready,
        output PC_write, PC_write_cond, IorD, Mem_read, Mem_write, IR_write,
               Mem_to_reg, Reg_dst, Reg_write, Alu_src_a, Alu_src_b, Alu_op,
               PC_source, Illegal_op, State
    );

    modport slave (
        output Opcode, Mem_ready,
        input  PC_write, PC_write_cond, IorD, Mem_read, Mem_write, IR_write,
               Mem_to_reg, Reg_dst, Reg_write, Alu_src_a, Alu_src_b, Alu_op,
               PC_source, Illegal_op, State
    );
endinterface
`default_nettype wire

// File: rtl/main_control_decode.sv
`default_nettype none
// ============================================================================
// Module   : main_control_decode
// Purpose  : State-to-control decode, gated by Mem_ready in FETCH and by rst.
// Revision : 1.0 - initial release
// ============================================================================
module main_control_decode
    import mips_pkg::*;
(
    input  wire logic       rst,
    input  var  state_t     state,
    input  wire logic [5:0] opcode,
    input  wire logic       mem_ready,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = ALUSRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b  = ALUSRCB_IMM_SH2;
                    ctrl.alu_op     = ALUOP_ADD;
                    ctrl.illegal_op = !is_legal_op(opcode);
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALUSRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALUSRCB_B;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = ALUSRCB_B;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                S_ADDI_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_control_fsm
// Purpose  : Multi-cycle MIPS main control: state register and sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module main_control_fsm
    import mips_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input wire logic           clk,
    input wire logic           rst,
    main_control_fsm_if.master bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= state_t'(RESET_STATE);
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = bus.Mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDI_EXEC;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next = (bus.Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = bus.Mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = bus.Mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_next = S_R_WB;
            S_ADDI_EXEC: w_next = S_ADDI_WB;
            // write-back, branch, jump and unreachable encodings all return to FETCH
            default:     w_next = S_FETCH;
        endcase
    end

    main_control_decode u_decode (
        .rst       (rst),
        .state     (r_state),
        .opcode    (bus.Opcode),
        .mem_ready (bus.Mem_ready),
        .ctrl      (w_ctrl)
    );

    assign bus.PC_write      = w_ctrl.pc_write;
    assign bus.PC_write_cond = w_ctrl.pc_write_cond;
    assign bus.IorD          = w_ctrl.iord;
    assign bus.Mem_read      = w_ctrl.mem_read;
    assign bus.Mem_write     = w_ctrl.mem_write;
    assign bus.IR_write      = w_ctrl.ir_write;
    assign bus.Mem_to_reg    = w_ctrl.mem_to_reg;
    assign bus.Reg_dst       = w_ctrl.reg_dst;
    assign bus.Reg_write     = w_ctrl.reg_write;
    assign bus.Alu_src_a     = w_ctrl.alu_src_a;
    assign bus.Alu_src_b     = w_ctrl.alu_src_b;
    assign bus.Alu_op        = w_ctrl.alu_op;
    assign bus.PC_source     = w_ctrl.pc_source;
    assign bus.Illegal_op    = w_ctrl.illegal_op;
    assign bus.State         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_control_fsm
// Purpose  : Directed + randomized instruction-level check of main_control_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    main_control_fsm_if bus ();

    main_control_fsm #(.RESET_STATE(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector layout: State, PC_write, PC_write_cond, IorD, Mem_read, Mem_write,
    // IR_write, Mem_to_reg, Reg_dst, Reg_write, Alu_src_a, Alu_src_b, Alu_op, PC_source, Illegal_op
    function automatic logic [20:0] observed();
        return {bus.State, bus.PC_write, bus.PC_write_cond, bus.IorD, bus.Mem_read,
                bus.Mem_write, bus.IR_write, bus.Mem_to_reg, bus.Reg_dst, bus.Reg_write,
                bus.Alu_src_a, bus.Alu_src_b, bus.Alu_op, bus.PC_source, bus.Illegal_op};
    endfunction

    // Expected control word for a given state, straight from the state table.
    function automatic logic [20:0] spec_outputs(int st, bit rdy, bit ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, il;
        logic [1:0] asb, aop, pcs;
        logic [3:0] s4;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, il} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        s4 = st[3:0];
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {s4, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, il};
    endfunction

    task automatic check(logic [20:0] o, logic [20:0] e, string tag);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    // Called at posedge+1: drive Mem_ready, check at negedge, return at next posedge+1.
    task automatic step(int st, bit rdy, bit ill, string tag);
        bus.Mem_ready = rdy;
        @(negedge clk);
        check(observed(), spec_outputs(st, rdy, ill), tag);
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: the list of states each opcode visits.
    function automatic void path_of(logic [5:0] op, ref int p[$]);
        p = {0, 1};
        case (op)
            6'b100011: p = {0, 1, 2, 3, 4};
            6'b101011: p = {0, 1, 2, 5};
            6'b000000: p = {0, 1, 6, 7};
            6'b000100: p = {0, 1, 8};
            6'b000010: p = {0, 1, 9};
            6'b001000: p = {0, 1, 10, 11};
            default:   p = {0, 1};
        endcase
    endfunction

    task automatic run_instr(logic [5:0] op, int fetch_stall, int mem_stall, string tag);
        int  p[$];
        bit  ill;
        ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
        bus.Opcode = op;
        path_of(op, p);
        foreach (p[i]) begin
            if (p[i] == 0 || p[i] == 3 || p[i] == 5) begin
                for (int k = 0; k < ((p[i] == 0) ? fetch_stall : mem_stall); k++)
                    step(p[i], 1'b0, 1'b0, tag);
                step(p[i], 1'b1, 1'b0, tag);
            end else begin
                step(p[i], 1'($urandom_range(0, 1)), ill && (p[i] == 1), tag);
            end
        end
    endtask

    initial begin
        logic [5:0] legal [6];
        logic [5:0] op;
        passed = 0;
        total  = 0;
        legal  = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        rst = 1'b0;
        bus.Opcode = 6'd0;
        bus.Mem_ready = 1'b1;

        // Asynchronous reset between clock edges
        #3 rst = 1'b1;
        #1 check(observed(), 21'd0, "reset_async");
        @(posedge clk); #1;
        check(observed(), 21'd0, "reset_held");
        rst = 1'b0;

        run_instr(6'b100011, 0, 0, "lw");
        run_instr(6'b101011, 0, 3, "sw_stall3");
        run_instr(6'b000000, 0, 0, "rtype");
        run_instr(6'b000100, 0, 0, "beq");
        run_instr(6'b001000, 2, 0, "addi_fetch_stall2");
        run_instr(6'b111111, 0, 0, "illegal");
        run_instr(6'b000010, 0, 0, "jump");
        run_instr(6'b100011, 1, 2, "lw_stall");

        // Reset mid-FETCH while Mem_ready is high: IR_write/PC_write must drop
        step(0, 1'b0, 1'b0, "fetch_pre_reset");
        bus.Mem_ready = 1'b1;
        @(negedge clk); #2;
        rst = 1'b1;
        #1 check(observed(), 21'd0, "reset_mid_fetch");
        @(posedge clk); #1;
        rst = 1'b0;
        run_instr(6'b000000, 0, 0, "rtype_after_reset");

        // Reset during lw write-back abandons the register write
        bus.Opcode = 6'b100011;
        step(0, 1'b1, 1'b0, "lw_abort");
        step(1, 1'b1, 1'b0, "lw_abort");
        step(2, 1'b1, 1'b0, "lw_abort");
        step(3, 1'b1, 1'b0, "lw_abort");
        bus.Mem_ready = 1'b1;
        @(negedge clk);
        check(observed(), spec_outputs(4, 1'b1, 1'b0), "lw_abort_wb");
        #2 rst = 1'b1;
        #1 check(observed(), 21'd0, "reset_mid_wb");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 6'($urandom_range(0, 63));
                while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
            end else begin
                op = legal[$urandom_range(0, 5)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_control_fsm.md
# main_control_fsm

Multi-cycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states from the 6-bit opcode. Drives every datapath enable and mux select, including the 2-bit `Alu_op` consumed by the ALU control decoder. Memory states stall on a `Mem_ready` handshake.

## Interface
Parameters:
- `RESET_STATE`, default 4'd0 (FETCH): state loaded on reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Opcode`  in  6  instruction[31:26] from the instruction register; sampled in DECODE.
- `Mem_ready`  in  1  memory has completed the current read or write this cycle.
- `PC_write`  out  1  unconditional PC load.
- `PC_write_cond`  out  1  PC load if ALU Zero.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `Mem_read`  out  1  memory read request.
- `Mem_write`  out  1  memory write request.
- `IR_write`  out  1  instruction register load.
- `Mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- `Reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `Reg_write`  out  1  register file write.
- `Alu_src_a`  out  1  ALU A input: 0 = PC, 1 = register A.
- `Alu_src_b`  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `Alu_op`  out  2  00 = add, 01 = subtract, 10 = decode funct field; 11 is never driven.
- `PC_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `Illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `State`  out  4  current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Anything else is illegal.
- Outputs are a Moore function of state. The one exception is gating by `Mem_ready`, described in the FETCH and memory states below.
- Any output not listed for a state is 0.

States and transitions:
- FETCH (0): `Mem_read`=1, `Alu_src_b`=01, `Alu_op`=00. `IR_write` and `PC_write` equal `Mem_ready`. Go to DECODE when `Mem_ready` is 1; otherwise stay.
- DECODE (1): `Alu_src_b`=11, `Alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEM_ADDR
  - R-type → R_EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EXEC
  - illegal → FETCH, with `Illegal_op`=1 in this cycle.
- MEM_ADDR (2): `Alu_src_a`=1, `Alu_src_b`=10, `Alu_op`=00. Go to MEM_READ for lw, MEM_WRITE for sw (opcode held in the IR).
- MEM_READ (3): `Mem_read`=1, `IorD`=1. Go to MEM_WB when `Mem_ready` is 1; otherwise stay.
- MEM_WB (4): `Reg_write`=1, `Mem_to_reg`=1, `Reg_dst`=0. Go to FETCH.
- MEM_WRITE (5): `Mem_write`=1, `IorD`=1. Go to FETCH when `Mem_ready` is 1; otherwise stay.
- R_EXEC (6): `Alu_src_a`=1, `Alu_src_b`=00, `Alu_op`=10. Go to R_WB.
- R_WB (7): `Reg_write`=1, `Reg_dst`=1, `Mem_to_reg`=0. Go to FETCH.
- BRANCH (8): `Alu_src_a`=1, `Alu_src_b`=00, `Alu_op`=01, `PC_write_cond`=1, `PC_source`=01. Go to FETCH.
- JUMP (9): `PC_write`=1, `PC_source`=10. Go to FETCH.
- ADDI_EXEC (10): `Alu_src_a`=1, `Alu_src_b`=10, `Alu_op`=00. Go to ADDI_WB.
- ADDI_WB (11): `Reg_write`=1, `Reg_dst`=0, `Mem_to_reg`=0. Go to FETCH.
- Encodings 12–15 are unreachable. If entered, go to FETCH on the next edge with all outputs 0.

## Timing
- Reset:
  - State = FETCH immediately on `rst` rising, independent of `clk`.
  - While `rst` is high, every output is forced to 0 except `State`, which reads 0.
  - FETCH behaviour starts on the first `clk` edge after `rst` deasserts.
- Reset mid-instruction abandons the instruction with no partial write. `Reg_write`, `Mem_write` and `PC_write` drop in the same cycle.
- Cycles per instruction with `Mem_ready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Wait states:
  - Each low `Mem_ready` cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
  - Request signals (`Mem_read`, `Mem_write`, `IorD`) stay stable throughout the wait.
- `Mem_ready` is ignored in every other state.
- `Opcode` is only sampled in DECODE and MEM_ADDR. It must be stable there, which is guaranteed because `IR_write`=0.
- No output glitch at a state transition: outputs decode from the state register only, plus `Mem_ready` in FETCH.

## Structure
- Shared `mips_pkg`, holding:
  - state encoding constants S_FETCH through S_ADDI_WB (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - `Alu_op` codes ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - `Alu_src_b` and `PC_source` select codes.
  These are shared with the ALU control decoder and the datapath.
- One sub-module, `main_control_decode`: combinational state-to-outputs decode, with `Mem_ready` and `rst` gating.
- The top level holds the state register and next-state logic.

## Test plan
- Reset asserted mid-FETCH between clock edges → `State`=0 and all enables 0 within the same cycle. FETCH resumes on the first edge after release.
- lw (Opcode 100011), `Mem_ready`=1 → states 0,1,2,3,4,0. `Reg_write`=1 and `Mem_to_reg`=1 only in state 4.
- sw with `Mem_ready` low for 3 cycles in MEM_WRITE → `Mem_write`=1 and `IorD`=1 held 4 cycles, then FETCH. `Reg_write` never asserts.
- R-type then beq → `Alu_op`=10 in state 6 and `Reg_dst`=1 in state 7. `Alu_op`=01 with `PC_write_cond`=1 in state 8.
- FETCH with `Mem_ready` low 2 cycles → `IR_write`=0 and `PC_write`=0 for 2 cycles, then both 1 for exactly one cycle.
- Opcode 111111 → `Illegal_op` pulses 1 for one cycle in DECODE, then FETCH. j (000010) → `PC_write`=1, `PC_source`=10 in state 9.
